// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the CPU data port.
// Accepts one word request in IDLE, answers with a single-cycle o_data_resp LATENCY cycles later.
module dmem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_data_read,
    input  logic        i_data_write,
    input  logic [31:0] i_data_addr,
    input  logic [3:0]  i_data_mbe,
    input  logic [31:0] i_data_wdata,
    output logic [31:0] o_data_rdata,
    output logic        o_data_resp,
    output logic        o_busy,
    output logic        o_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [3:0]             r_mbe;
    logic [31:0]            r_wdata;
    logic                   r_write;
    logic                   r_oor;
    logic [31:0]            r_rdata;
    logic                   r_err;
    logic [31:0]            r_mem [DEPTH];

    logic                   w_req;
    logic                   w_oor;
    logic                   w_accept;
    logic                   w_enter_resp;
    logic [ADDR_BITS-1:0]   w_cur_idx;
    logic [3:0]             w_cur_mbe;
    logic [31:0]            w_cur_wdata;
    logic                   w_cur_write;
    logic                   w_cur_oor;
    logic                   w_mem_we;
    logic                   w_unused;

    assign w_req    = i_data_read | i_data_write;
    assign w_oor    = |i_data_addr[31:ADDR_BITS+2];
    assign w_unused = ^i_data_addr[1:0];

    // With LATENCY=1 the RESP transition happens on the accept edge, so the
    // commit/read must use the live inputs rather than the latched copy.
    assign w_cur_idx   = (r_state == S_IDLE) ? i_data_addr[ADDR_BITS+1:2] : r_idx;
    assign w_cur_mbe   = (r_state == S_IDLE) ? i_data_mbe   : r_mbe;
    assign w_cur_wdata = (r_state == S_IDLE) ? i_data_wdata : r_wdata;
    assign w_cur_write = (r_state == S_IDLE) ? i_data_write : r_write;
    assign w_cur_oor   = (r_state == S_IDLE) ? w_oor        : r_oor;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_mbe   <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_oor   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx   <= i_data_addr[ADDR_BITS+1:2];
                r_mbe   <= i_data_mbe;
                r_wdata <= i_data_wdata;
                r_write <= i_data_write;
                r_oor   <= w_oor;
                if (w_oor || (i_data_read && i_data_write)) begin
                    r_err <= 1'b1;
                end
            end
            if (w_enter_resp && !w_cur_write) begin
                r_rdata <= w_cur_oor ? 32'h0 : r_mem[w_cur_idx];
            end
        end
    end

    // Array is deliberately not reset; reset only blocks the commit.
    assign w_mem_we = w_enter_resp && w_cur_write && !w_cur_oor && !i_rst;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_cur_mbe[i]) begin
                    r_mem[w_cur_idx][8*i +: 8] <= w_cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_data_rdata = r_rdata;
    assign o_data_resp  = (r_state == S_RESP);
    assign o_busy       = (r_state != S_IDLE);
    assign o_err        = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, directed corner sequences,
// and randomized traffic against a byte-addressed reference memory.
module tb_dmem_responder;

    localparam int LAT = 3;
    localparam int AB  = 8;
    localparam int NBYTES = 4 * (1 << AB);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  mbe = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        resp;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    byte unsigned mem_b [NBYTES];
    logic [31:0]  exp_last_rd = 32'h0;
    bit           exp_err = 1'b0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  mbe;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [10];

    dmem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data_read  (rd),
        .i_data_write (wr),
        .i_data_addr  (addr),
        .i_data_mbe   (mbe),
        .i_data_wdata (wdata),
        .o_data_rdata (rdata),
        .o_data_resp  (resp),
        .o_busy       (busy),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, anything at or beyond NBYTES is out of range.
    function automatic logic [31:0] model_access(bit r, bit w, logic [31:0] a, logic [3:0] m,
                                                 logic [31:0] d);
        logic [31:0] base;
        bit          in_range;
        base     = a & 32'hFFFF_FFFC;
        in_range = (base < NBYTES);
        if (!in_range || (r && w)) exp_err = 1'b1;
        if (w) begin
            if (in_range)
                for (int i = 0; i < 4; i++)
                    if (m[i]) mem_b[base + i] = d[8*i +: 8];
        end else begin
            if (in_range)
                exp_last_rd = {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
            else
                exp_last_rd = 32'h0;
        end
        return exp_last_rd;
    endfunction

    task automatic xact(input bit r, input bit w, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, input string tag, output logic [31:0] got);
        int          lat;
        logic [31:0] exp;
        @(negedge clk);
        rd = r; wr = w; addr = a; mbe = m; wdata = d;
        exp = model_access(r, w, a, m, d);
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) chk({tag, " busy_wait"}, 32'(busy), 32'd1);
            if (resp) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, lat, LAT);
        got = rdata;
        chk({tag, " rdata"}, rdata, exp);
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk({tag, " resp_pulse"}, 32'(resp), 32'd0);
        chk({tag, " busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] exp;
        int          cyc;
        int          prev;
        int          lat;
        bit          found;
        int          nresp;

        vt[0] = '{1'b0, 1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0};
        vt[1] = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        32'hDEADBEEF};
        vt[2] = '{1'b0, 1'b1, 32'h10,  4'h4, 32'h00AA0000, 32'h0};
        vt[3] = '{1'b1, 1'b0, 32'h10,  4'hF, 32'h0,        32'hDEAABEEF};
        vt[4] = '{1'b0, 1'b1, 32'h10,  4'h0, 32'h12345678, 32'h0};
        vt[5] = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        32'hDEAABEEF};
        vt[6] = '{1'b1, 1'b0, 32'h400, 4'h0, 32'h0,        32'h0};
        vt[7] = '{1'b1, 1'b0, 32'h10,  4'h0, 32'h0,        32'hDEAABEEF};
        vt[8] = '{1'b1, 1'b1, 32'h14,  4'hF, 32'hCAFEF00D, 32'h0};
        vt[9] = '{1'b1, 1'b0, 32'h14,  4'h0, 32'h0,        32'hCAFEF00D};

        // Reset state
        #2 rst = 1'b1;
        #10;
        chk("reset resp", 32'(resp), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Preload words 0..8; word 8 (0x20) gets a known value for the abort test
        for (int i = 0; i < 8; i++)
            xact(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom, "preload", got);
        xact(1'b0, 1'b1, 32'h20, 4'hF, 32'h11111111, "preload20", got);

        // Vector table: basic write/read, partial mbe, mbe=0, out-of-range, read&write
        for (int i = 0; i < 10; i++) begin
            xact(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].mbe, vt[i].wd, $sformatf("vec%0d", i), got);
            if (vt[i].rd && !vt[i].wr) chk($sformatf("vec%0d table_rdata", i), got, vt[i].exp_rd);
        end
        chk("err sticky", 32'(err), 32'd1);

        // Back-to-back reads held continuously
        cyc = 0; prev = 0;
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 32'h0;
        exp = model_access(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            found = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                cyc++;
                if (resp) begin
                    found = 1'b1;
                    break;
                end
            end
            chk($sformatf("b2b%0d resp_seen", i), 32'(found), 32'd1);
            chk($sformatf("b2b%0d rdata", i), rdata, exp);
            if (i > 0) chk($sformatf("b2b%0d spacing", i), cyc - prev, LAT + 1);
            prev = cyc;
            if (i < 2) begin
                addr = 32'((i + 1) * 4);
                exp  = model_access(1'b1, 1'b0, addr, 4'h0, 32'h0);
            end else begin
                rd = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b busy_idle", 32'(busy), 32'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 60; n++) begin
            bit          r, w;
            logic [31:0] a;
            int          kind;
            kind = $urandom_range(0, 15);
            r = (kind < 7) || (kind == 15);
            w = (kind >= 7);
            a = 32'($urandom_range(0, 7) * 4);
            if (kind == 6 || kind == 14) a = a | (32'h1 << $urandom_range(AB + 2, 31));
            xact(r, w, a, 4'($urandom_range(0, 15)), $urandom, $sformatf("rnd%0d", n), got);
        end

        // Async reset during WAIT of a write aborts it
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; addr = 32'h20; mbe = 4'hF; wdata = 32'h22222222;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort resp", 32'(resp), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort err", 32'(err), 32'd0);
        chk("abort rdata", rdata, 32'h0);
        wr = 1'b0;
        exp_err = 1'b0;
        exp_last_rd = 32'h0;
        nresp = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp) nresp++;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp) nresp++;
        end
        chk("abort no_resp", nresp, 0);
        xact(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, "abort readback", got);
        chk("abort old_value", got, 32'h11111111);

        // Requester drops the read one cycle after accept
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 32'h4;
        exp = model_access(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) rd = 1'b0;
            if (resp) begin
                lat = c;
                break;
            end
        end
        chk("drop latency", lat, LAT);
        chk("drop rdata", rdata, exp);
        @(negedge clk);
        chk("drop resp_pulse", 32'(resp), 32'd0);
        chk("drop busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("drop stays_idle", 32'(busy), 32'd0);
        chk("drop rdata_held", rdata, exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
